// File: rtl/irq_pkg.sv
// Shared types for the interrupt front end: request vector width and encoder index type.
package irq_pkg;

   localparam int unsigned N_IRQ = 4;

   typedef logic [N_IRQ-1:0]         irq_vec_t;
   typedef logic [$clog2(N_IRQ)-1:0] irq_id_t;

endpackage

// File: rtl/sync_rise_detect.sv
// One-bit synchroniser followed by a rising-edge detector on the synchronised level.
module sync_rise_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_reset,
   input  logic d_async,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
      s_d_d  = sync_q[SYNC_STAGES-1];
   end

   // s_d resets low so a request held high through reset still yields one event.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s_d_q  <= s_d_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Turns raw asynchronous request levels into sticky, maskable pending bits for the
// priority encoder, cleared by acknowledging the encoder index; flags lost events.
module irq_pending_latch
   import irq_pkg::*;
#(
   parameter  int unsigned N           = N_IRQ,
   parameter  int unsigned SYNC_STAGES = 2,
   localparam int unsigned IDW         = $clog2(N)
) (
   input  logic           clk,
   input  logic           n_reset,
   input  logic [N-1:0]   req_raw,
   input  logic [N-1:0]   mask,
   input  logic           ack,
   input  logic [IDW-1:0] ack_id,
   input  logic           overflow_clr,
   output logic [N-1:0]   pending,
   output logic           any_pending,
   output logic [N-1:0]   overflow
);

   logic [N-1:0] rise;
   logic [N-1:0] ack_hit;
   logic [N-1:0] lat_q, lat_d;
   logic [N-1:0] ovf_q, ovf_d;

   for (genvar i = 0; i < N; i++) begin : g_line
      sync_rise_detect #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .n_reset(n_reset),
         .d_async(req_raw[i]),
         .rise   (rise[i])
      );
   end

   // Out-of-range ack_id (non-power-of-2 N) matches no line and is ignored.
   always_comb begin
      ack_hit = '0;
      for (int i = 0; i < N; i++) begin
         if (ack && (ack_id == IDW'(i))) begin
            ack_hit[i] = 1'b1;
         end
      end
   end

   // A new event beats a same-cycle ack and is not counted as lost.
   always_comb begin
      lat_d = rise | (lat_q & ~ack_hit);
      ovf_d = (overflow_clr ? '0 : ovf_q) | (rise & lat_q & ~ack_hit);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         lat_q <= '0;
         ovf_q <= '0;
      end else begin
         lat_q <= lat_d;
         ovf_q <= ovf_d;
      end
   end

   assign pending     = lat_q & ~mask;
   assign any_pending = |pending;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed scenarios plus randomized traffic against a delay-line reference model.
module tb_irq_pending_latch;
   import irq_pkg::*;

   localparam int unsigned SS = 2;

   logic     clk          = 1'b0;
   logic     n_reset      = 1'b0;
   irq_vec_t req_raw      = '0;
   irq_vec_t mask         = '0;
   logic     ack          = 1'b0;
   irq_id_t  ack_id       = '0;
   logic     overflow_clr = 1'b0;
   irq_vec_t pending;
   irq_vec_t overflow;
   logic     any_pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   irq_pending_latch #(
      .N          (N_IRQ),
      .SYNC_STAGES(SS)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .req_raw     (req_raw),
      .mask        (mask),
      .ack         (ack),
      .ack_id      (ack_id),
      .overflow_clr(overflow_clr),
      .pending     (pending),
      .any_pending (any_pending),
      .overflow    (overflow)
   );

   // Reference: an event is a 0->1 step in req_raw seen SS edges late.
   irq_vec_t samp [0:SS];
   irq_vec_t m_lat = '0;
   irq_vec_t m_ovf = '0;
   irq_vec_t m_ev, m_hit;

   initial for (int j = 0; j <= SS; j++) samp[j] = '0;

   assign m_ev  = samp[SS-1] & ~samp[SS];
   assign m_hit = ack ? irq_vec_t'(4'b0001 << ack_id) : '0;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int j = 0; j <= SS; j++) samp[j] <= '0;
         m_lat <= '0;
         m_ovf <= '0;
      end else begin
         samp[0] <= req_raw;
         for (int j = 1; j <= SS; j++) samp[j] <= samp[j-1];
         m_lat <= m_ev | (m_lat & ~m_hit);
         m_ovf <= (overflow_clr ? '0 : m_ovf) | (m_ev & m_lat & ~m_hit);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int line, input int hi);
      req_raw[line] = 1'b1;
      cyc(hi);
      req_raw[line] = 1'b0;
   endtask

   task automatic do_ack(input int id);
      ack    = 1'b1;
      ack_id = irq_id_t'(id);
      cyc(1);
      ack    = 1'b0;
   endtask

   task automatic clean();
      req_raw = '0;
      mask    = '0;
      cyc(4);
      for (int i = 0; i < N_IRQ; i++) do_ack(i);
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      req_raw = 4'b1111;
      cyc(2);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got=%b want=0000", pending); end
      checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL rst_any got=%b want=0", any_pending); end
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL rst_ovf got=%b want=0000", overflow); end
      n_reset = 1'b1;
      cyc(1);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rel_edge1 got=%b want=0000", pending); end
      cyc(1);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rel_edge2 got=%b want=0000", pending); end
      cyc(1);
      checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL rel_edge3 got=%b want=1111", pending); end
      checks++; if (any_pending !== 1'b1) begin errors++; $display("FAIL rel_any got=%b want=1", any_pending); end
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL rel_ovf got=%b want=0000", overflow); end
      clean();
   endtask

   task automatic test_pulse_ack();
      req_raw[2] = 1'b1;
      cyc(2);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL pulse_early got=%b want=0000", pending); end
      cyc(1);
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL pulse_set got=%b want=0100", pending); end
      cyc(2);
      req_raw[2] = 1'b0;
      cyc(4);
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL pulse_sticky got=%b want=0100", pending); end
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL pulse_ovf got=%b want=0000", overflow); end
      do_ack(2);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ack_clear got=%b want=0000", pending); end
      checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL ack_any got=%b want=0", any_pending); end
      clean();
   endtask

   task automatic test_overflow();
      pulse(1, 2);
      cyc(4);
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovf_first got=%b want=0010", pending); end
      pulse(1, 2);
      cyc(2);
      checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_set got=%b want=0010", overflow); end
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovf_pend got=%b want=0010", pending); end
      overflow_clr = 1'b1;
      cyc(1);
      overflow_clr = 1'b0;
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clr got=%b want=0000", overflow); end
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovf_clr_pend got=%b want=0010", pending); end
      clean();
   endtask

   task automatic test_ack_collision();
      pulse(3, 2);
      cyc(4);
      checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL col_first got=%b want=1000", pending); end
      req_raw[3] = 1'b1;
      cyc(2);
      ack    = 1'b1;
      ack_id = 2'd3;
      cyc(1);
      ack    = 1'b0;
      checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL col_pend got=%b want=1000", pending); end
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL col_ovf got=%b want=0000", overflow); end
      clean();
   endtask

   task automatic test_mask();
      int y;
      mask = 4'b1000;
      pulse(3, 2);
      cyc(4);
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mask_hide got=%b want=0000", pending); end
      checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL mask_any got=%b want=0", any_pending); end
      mask = 4'b0000;
      #1;
      checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL unmask got=%b want=1000", pending); end
      checks++; if (any_pending !== 1'b1) begin errors++; $display("FAIL unmask_any got=%b want=1", any_pending); end
      pulse(1, 2);
      cyc(4);
      checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL enc_a got=%b want=1010", pending); end
      y = pending[3] ? 3 : pending[2] ? 2 : pending[1] ? 1 : 0;
      checks++; if (y != 3) begin errors++; $display("FAIL enc_y got=%0d want=3", y); end
      do_ack(y);
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL enc_ack got=%b want=0010", pending); end
      mask = 4'b0010;
      do_ack(1);
      mask = 4'b0000;
      #1;
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL masked_ack got=%b want=0000", pending); end
      do_ack(0);
      checks++; if (pending !== 4'b0000 || overflow !== 4'b0000) begin
         errors++; $display("FAIL idle_ack got=%b/%b want=0000/0000", pending, overflow);
      end
      clean();
   endtask

   task automatic test_async_reset();
      req_raw = 4'b0110;
      cyc(2);
      req_raw = 4'b0000;
      cyc(4);
      pulse(1, 2);
      cyc(2);
      checks++; if (pending !== 4'b0110) begin errors++; $display("FAIL ar_pend got=%b want=0110", pending); end
      checks++; if (overflow !== 4'b0010) begin errors++; $display("FAIL ar_ovf got=%b want=0010", overflow); end
      #2 n_reset = 1'b0;
      #1;
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ar_rst_pend got=%b want=0000", pending); end
      checks++; if (any_pending !== 1'b0) begin errors++; $display("FAIL ar_rst_any got=%b want=0", any_pending); end
      checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ar_rst_ovf got=%b want=0000", overflow); end
      cyc(2);
      n_reset = 1'b1;
      cyc(4);
   endtask

   task automatic test_random();
      int       hold = 0;
      irq_vec_t exp_p;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (hold == 0) begin
            req_raw = irq_vec_t'($urandom);
            hold    = $urandom_range(1, 4);
         end
         hold--;
         if ($urandom_range(0, 3) == 0) mask = irq_vec_t'($urandom);
         ack          = ($urandom_range(0, 2) == 0);
         ack_id       = irq_id_t'($urandom);
         overflow_clr = ($urandom_range(0, 9) == 0);
         #1;
         exp_p = m_lat & ~mask;
         checks++; if (pending !== exp_p || any_pending !== |exp_p || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand c=%0d got p=%b a=%b o=%b want p=%b a=%b o=%b", c, pending,
                     any_pending, overflow, exp_p, |exp_p, m_ovf);
         end
      end
      ack          = 1'b0;
      overflow_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pulse_ack();
      test_overflow();
      test_ack_collision();
      test_mask();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
